// File: rtl/count_fsm_gen_pkg.sv
// count_fsm_gen_pkg
//   Shared types and constants for the count_fsm_gen start/wait/count controller.
//   state_e      : FSM state encoding (IDLE, WAIT, COUNT)
//   MODE_*       : values of mode_reload (one-shot / auto-reload)
//   DIR_*        : values of dir_down (count up / count down)
package count_fsm_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    COUNT = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/count_fsm_gen_prescaler.sv
// count_fsm_gen_prescaler
//   Tick generator: asserts tick once every div+1 cycles while clear is low.
//   Ports:
//     clk    in  clock, rising edge
//     rst_n  in  asynchronous active-low reset
//     clear  in  synchronous restart of the divider phase
//     div    in  PS_W  divide value (tick period = div+1 cycles)
//     tick   out combinational tick strobe
module count_fsm_gen_prescaler #(
  parameter int unsigned PS_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic [PS_W-1:0] div,
  output logic            tick
);

  logic [PS_W-1:0] cnt_q;

  assign tick = (cnt_q == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PS_W'(1);
    end
  end

endmodule

// File: rtl/count_fsm_gen.sv
// count_fsm_gen
//   Start/wait/count controller. After start (in IDLE) it waits wait_timer
//   cycles, then counts up to term_value or down to 0, one-shot or
//   auto-reload, with synchronous abort via stop.
//   Optional feature macro: COUNT_FSM_GEN_PRESCALE_EN (adds PS_W / prescale,
//   one tick every prescale+1 cycles in COUNT).
//   Ports:
//     clk, rst_n          clock (rising edge) / asynchronous active-low reset
//     start               run request, sampled only in IDLE
//     stop                synchronous abort
//     mode_reload         1 = auto-reload, 0 = one-shot
//     dir_down            1 = count down, 0 = count up
//     wait_timer [WAIT_W] pre-count wait length in cycles
//     term_value [CNT_W]  terminal value
//     prescale   [PS_W]   tick divider (macro only)
//     busy                high in WAIT or COUNT
//     flag                one-cycle pulse on terminal tick
//     count_value[CNT_W]  current count
module count_fsm_gen
  import count_fsm_gen_pkg::*;
#(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned WAIT_W = 8
`ifdef COUNT_FSM_GEN_PRESCALE_EN
  ,
  parameter int unsigned PS_W   = 4
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              mode_reload,
  input  logic              dir_down,
  input  logic [WAIT_W-1:0] wait_timer,
  input  logic [CNT_W-1:0]  term_value,
`ifdef COUNT_FSM_GEN_PRESCALE_EN
  input  logic [PS_W-1:0]   prescale,
`endif
  output logic              busy,
  output logic              flag,
  output logic [CNT_W-1:0]  count_value
);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  term_q, term_d;
  logic              reload_q, reload_d;
  logic              down_q, down_d;
  logic              busy_q, busy_d;
  logic              flag_q, flag_d;
  logic [CNT_W-1:0]  target;
  logic              tick;

`ifdef COUNT_FSM_GEN_PRESCALE_EN
  logic [PS_W-1:0]   ps_q, ps_d;
  logic              ps_clear;

  // Divider phase restarts on every COUNT entry (held clear outside COUNT)
  // and on a reload, so each run sees a full prescale period per tick.
  assign ps_clear = (state_q != COUNT) || flag_d;

  count_fsm_gen_prescaler #(
    .PS_W (PS_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (ps_clear),
    .div   (ps_q),
    .tick  (tick)
  );
`else
  assign tick = 1'b1;
`endif

  assign target = (down_q == DIR_DOWN) ? '0 : term_q;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    count_d  = count_q;
    term_d   = term_q;
    reload_d = reload_q;
    down_d   = down_q;
    busy_d   = busy_q;
    flag_d   = 1'b0;
`ifdef COUNT_FSM_GEN_PRESCALE_EN
    ps_d     = ps_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          term_d   = term_value;
          reload_d = mode_reload;
          down_d   = dir_down;
          wait_d   = wait_timer;
`ifdef COUNT_FSM_GEN_PRESCALE_EN
          ps_d     = prescale;
`endif
          count_d  = (dir_down == DIR_DOWN) ? term_value : '0;
          busy_d   = 1'b1;
          state_d  = (wait_timer == '0) ? COUNT : WAIT;
        end
      end
      WAIT: begin
        if (stop) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (wait_q == WAIT_W'(1)) begin
          wait_d  = '0;
          state_d = COUNT;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      COUNT: begin
        if (stop) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (tick) begin
          if (count_q == target) begin
            flag_d = 1'b1;
            if (reload_q == MODE_RELOAD) begin
              count_d = (down_q == DIR_DOWN) ? term_q : '0;
            end else begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end else if (down_q == DIR_DOWN) begin
            count_d = count_q - CNT_W'(1);
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      count_q  <= '0;
      term_q   <= '0;
      reload_q <= MODE_ONESHOT;
      down_q   <= DIR_UP;
      busy_q   <= 1'b0;
      flag_q   <= 1'b0;
`ifdef COUNT_FSM_GEN_PRESCALE_EN
      ps_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      count_q  <= count_d;
      term_q   <= term_d;
      reload_q <= reload_d;
      down_q   <= down_d;
      busy_q   <= busy_d;
      flag_q   <= flag_d;
`ifdef COUNT_FSM_GEN_PRESCALE_EN
      ps_q     <= ps_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign flag        = flag_q;
  assign count_value = count_q;

endmodule

// File: tb/tb_count_fsm_gen.sv
// tb_count_fsm_gen
//   Directed bench for count_fsm_gen (default CNT_W=8, WAIT_W=8).
//   Edge numbering: the edge that samples start is edge 0; outputs are
//   sampled 1 time unit after each rising edge.
module tb_count_fsm_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       mode_reload;
  logic       dir_down;
  logic [7:0] wait_timer;
  logic [7:0] term_value;
`ifdef COUNT_FSM_GEN_PRESCALE_EN
  logic [3:0] prescale;
`endif
  logic       busy;
  logic       flag;
  logic [7:0] count_value;

  int unsigned total = 0;
  int unsigned bad   = 0;

  count_fsm_gen #(
    .CNT_W  (8),
    .WAIT_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .mode_reload (mode_reload),
    .dir_down    (dir_down),
    .wait_timer  (wait_timer),
    .term_value  (term_value),
`ifdef COUNT_FSM_GEN_PRESCALE_EN
    .prescale    (prescale),
`endif
    .busy        (busy),
    .flag        (flag),
    .count_value (count_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic b, input logic f, input logic [7:0] c);
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    check({tag, ".flag"}, {31'd0, flag}, {31'd0, f});
    check({tag, ".count"}, {24'd0, count_value}, {24'd0, c});
  endtask

  // W=3, T=5, up, one-shot. After edge 0 the inputs are scrambled and start is
  // re-pulsed at edge 5; the run must follow the values latched at edge 0.
  // Expected: count 0 through edge 3, 1..5 at edges 4..8, flag+busy=0 at edge 9.
  task automatic run_w3_t5(input string tag, input bit tail);
    logic [7:0] c_exp;
    wait_timer  = 8'd3;
    term_value  = 8'd5;
    dir_down    = 1'b0;
    mode_reload = 1'b0;
    start       = 1'b1;
    step();
    chk_out({tag, ".e0"}, 1'b1, 1'b0, 8'd0);
    start       = 1'b0;
    term_value  = 8'd2;
    wait_timer  = 8'd7;
    dir_down    = 1'b1;
    mode_reload = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      start = (e == 5);
      step();
      c_exp = (e <= 3) ? 8'd0 : (e <= 8) ? 8'(e - 3) : 8'd5;
      chk_out($sformatf("%s.e%0d", tag, e), (e < 9), (e == 9), c_exp);
    end
    start = 1'b0;
    if (tail) begin
      step();
      chk_out({tag, ".hold"}, 1'b0, 1'b0, 8'd5);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode_reload = 1'b0; dir_down = 1'b0;
    wait_timer = '0; term_value = '0;
`ifdef COUNT_FSM_GEN_PRESCALE_EN
    prescale = '0;
`endif
    #12;
    chk_out("reset", 1'b0, 1'b0, 8'd0);
    step();
    rst_n = 1'b1;
    step();
    chk_out("idle", 1'b0, 1'b0, 8'd0);

    // One-shot up run with ignored mid-run changes.
    run_w3_t5("oneshot", 1'b1);

    // Reset mid-COUNT: outputs clear without a clock edge.
    wait_timer = 8'd3; term_value = 8'd5; dir_down = 1'b0; mode_reload = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 1; e <= 6; e++) step();
    chk_out("pre_rst", 1'b1, 1'b0, 8'd3);
    rst_n = 1'b0;
    #2;
    chk_out("async_rst", 1'b0, 1'b0, 8'd0);
    step();
    rst_n = 1'b1;
    step();
    // Run after reset, no tail: restart on the very cycle busy drops.
    run_w3_t5("after_rst", 1'b0);

    // W=0, T=4, down, auto-reload: start accepted on the flag cycle.
    wait_timer = 8'd0; term_value = 8'd4; dir_down = 1'b1; mode_reload = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("reload.e0", 1'b1, 1'b0, 8'd4);
    for (int e = 1; e <= 12; e++) begin
      step();
      chk_out($sformatf("reload.e%0d", e), 1'b1, (e % 5 == 0), 8'(4 - (e % 5)));
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_out("reload.stop", 1'b0, 1'b0, 8'd2);

    // stop coincident with terminal tick: T=2, up, W=0.
    wait_timer = 8'd0; term_value = 8'd2; dir_down = 1'b0; mode_reload = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("term_stop.e0", 1'b1, 1'b0, 8'd0);
    step();
    step();
    chk_out("term_stop.e2", 1'b1, 1'b0, 8'd2);
    stop = 1'b1;
    step();
    chk_out("term_stop.e3", 1'b0, 1'b0, 8'd2);
    // start together with stop in IDLE is ignored.
    start = 1'b1;
    step();
    chk_out("start_stop", 1'b0, 1'b0, 8'd2);
    start = 1'b0;
    stop  = 1'b0;
    step();
    chk_out("idle_after", 1'b0, 1'b0, 8'd2);

    // Degenerate T=0 up: first tick is terminal.
    wait_timer = 8'd0; term_value = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("t0.e0", 1'b1, 1'b0, 8'd0);
    step();
    chk_out("t0.e1", 1'b0, 1'b1, 8'd0);

`ifdef COUNT_FSM_GEN_PRESCALE_EN
    // P=2, W=1, T=3, up, one-shot: steps at edges 4,7,10, flag at edge 13.
    wait_timer = 8'd1; term_value = 8'd3; prescale = 4'd2; mode_reload = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("ps.e0", 1'b1, 1'b0, 8'd0);
    for (int e = 1; e <= 13; e++) begin
      step();
      chk_out($sformatf("ps.e%0d", e), (e < 13), (e == 13),
              (e < 4) ? 8'd0 : (e < 7) ? 8'd1 : (e < 10) ? 8'd2 : 8'd3);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_fsm_gen.md
# count_fsm_gen

Parametrised start/wait/count controller, successor to the fixed-width counter FSM. After a `start` request it waits a programmable number of cycles, then counts up or down to a programmable terminal value. It supports one-shot or auto-reload operation and a synchronous abort. It sits in the control path as a general timing/sequencing engine with a `busy`/`flag` status interface.

## Interface
- `CNT_W`, default 8: width of `count_value` and `term_value`.
- `WAIT_W`, default 8: width of `wait_timer`.
- `PS_W`, default 4: prescaler width; exists only with `COUNT_FSM_GEN_PRESCALE_EN`.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `stop`  in  1  synchronous abort.
- `mode_reload`  in  1  selects mode: 1 = auto-reload, 0 = one-shot.
- `dir_down`  in  1  selects direction: 1 = count down, 0 = count up.
- `wait_timer`  in  `WAIT_W`  pre-count wait length, in cycles.
- `term_value`  in  `CNT_W`  terminal value.
- `prescale`  in  `PS_W`  tick divider; exists only with the macro.
- `busy`  out  1  high in WAIT or COUNT.
- `flag`  out  1  one-cycle pulse when the terminal value is reached.
- `count_value`  out  `CNT_W`  current count.

## Operation
- Reset values: state IDLE; `busy`=0, `flag`=0, `count_value`=0; internal wait and prescale counters cleared.
- States are IDLE, WAIT and COUNT. All outputs are registered.
- **IDLE**
  - When `start`=1 and `stop`=0: latch `wait_timer`, `term_value`, `mode_reload`, `dir_down` (and `prescale`).
  - Load `count_value` with the start value: 0 when counting up, T when counting down. T is the latched terminal value.
  - Go to WAIT, or directly to COUNT if the latched wait is 0.
- **WAIT**
  - The wait counter loads W and decrements each cycle.
  - At value 1 the FSM moves to COUNT. WAIT therefore lasts exactly W cycles.
- **COUNT**
  - On each tick, `count_value` moves by ±1. The target is T when counting up, 0 when counting down.
  - A tick with `count_value` already equal to the target is a terminal tick. It is not a step.
  - On a terminal tick, `flag`=1 for one cycle.
    - One-shot: go to IDLE, `busy`=0 in the same cycle as the `flag` pulse, `count_value` holds at the target.
    - Auto-reload: reload the start value, stay in COUNT, `busy` stays 1.
- Degenerate case: T=0 when counting up (or when counting down) makes the first tick a terminal tick.
- Arithmetic is unsigned modulo 2^`CNT_W`. The count never passes the target, so no wrap occurs. Latched inputs are immune to mid-run changes.
- `stop`=1 in WAIT or COUNT: go to IDLE on the next edge, `busy`=0, no `flag`, `count_value` holds.
- `stop` beats a simultaneous terminal tick: no `flag`.
- `stop` with `start` in IDLE: the `start` is ignored.
- `start` while `busy`=1 is ignored; there is no queuing.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronously).

## Timing
- `start` is sampled at edge 0. `busy`=1 after edge 0.
- WAIT occupies edges 1..W. Ticks begin at edge W+1.
- Without prescale, counting up: `count_value`=T after edge W+T. `flag`=1 and (one-shot) `busy`=0 after edge W+T+1.
- Counting down gives the same latency: T steps, then the terminal tick.
- Auto-reload period: T+1 ticks between `flag` pulses.
- Minimum turnaround: a new `start` is accepted on the cycle in which `busy` is low.

## Configuration
- Macro `COUNT_FSM_GEN_PRESCALE_EN`.
- Defined:
  - `PS_W` and the `prescale` port exist.
  - In COUNT, one tick occurs every P+1 cycles, where P is the latched prescale.
  - The prescale counter clears on COUNT entry and on reload. WAIT is unaffected.
- Undefined: the `prescale` port and `PS_W` are absent, and a tick occurs on every COUNT cycle.

## Structure
- Package `count_fsm_gen_pkg` holds:
  - the state typedef `state_e` {IDLE, WAIT, COUNT};
  - `MODE_ONESHOT`/`MODE_RELOAD` constants;
  - `DIR_UP`/`DIR_DOWN` constants.
- Sub-module `count_fsm_gen_prescaler`: a tick generator with `clk`, `rst_n`, `clear`, `div`, `tick`. It is instantiated only under the macro.
- The FSM, wait counter and main counter stay in the top module.

## Test plan
- Reset mid-COUNT (W=3, T=5, up) -> `busy`=0, `flag`=0, `count_value`=0 immediately; after release, `start` is accepted normally.
- W=3, T=5, up, one-shot, `start` at edge 0 -> `busy` high after edge 0; `count_value` 0..5; `flag` single pulse after edge 9, coincident with `busy`=0; `count_value` stays 5.
- W=0, T=4, down, auto-reload -> COUNT after edge 0; sequence 4,3,2,1,0,4,...; `flag` every 5 cycles; `busy` stays high until `stop`.
- `stop` on the same edge as a terminal tick (T=2, up) -> no `flag`, IDLE next cycle, `count_value`=2. `start`+`stop` together in IDLE -> no start.
- `start` pulses while busy, and `term_value`/`wait_timer` changed mid-run -> ignored; timing matches the original latched values.
- With macro: P=2, W=1, T=3, up -> one step every 3 cycles; `flag` after edge 1+3·4=13.
